regfile_reader: RTL and testbench

- 32 x 32-bit general-purpose register file for the miniRISC datapath.
- One synchronous write port and two combinational read ports, with same-cycle write-to-read bypass. Register 0 is hardwired to zero.
- Adds a debug readback sequencer: on request, it walks every register and streams (address, data) pairs out over a valid/ready handshake to the debug/trace unit.

---
 rtl/regfile_reader_if.sv | 33 +++
 rtl/regfile_reader.sv | 131 +++++++++++++
 tb/tb_regfile_reader.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_reader_if.sv
// Bus bundle for the miniRISC register file: write port, two read ports,
// and the debug readback stream (valid/ready) toward the trace unit.
interface regfile_reader_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata2;
    logic              dump_start;
    logic              dump_busy;
    logic              dump_valid;
    logic              dump_ready;
    logic [ADDR_W-1:0] dump_addr;
    logic [DATA_W-1:0] dump_data;
    logic              dump_done;

    // Datapath / debug unit side.
    modport master (
        output we, waddr, wdata, raddr1, raddr2, dump_start, dump_ready,
        input  rdata1, rdata2, dump_busy, dump_valid, dump_addr, dump_data, dump_done
    );

    // Register file side.
    modport slave (
        input  we, waddr, wdata, raddr1, raddr2, dump_start, dump_ready,
        output rdata1, rdata2, dump_busy, dump_valid, dump_addr, dump_data, dump_done
    );
endinterface

// File: rtl/regfile_reader.sv
// 32 x 32-bit register file, one write port, two combinational read ports
// with write-to-read bypass, r0 hardwired to zero, plus a debug sequencer
// that streams every (index, value) pair over a valid/ready handshake.
module regfile_reader #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              CLK,
    input  logic              RST_N,
    regfile_reader_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND,
        DONE
    } dump_state_t;

    logic [DATA_W-1:0] regs [NREGS];

    dump_state_t       state;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] idx_rdata;
    logic              busy_q;
    logic              valid_q;
    logic              done_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    // Shared read rule: r0 reads zero, a same-cycle write to the address wins,
    // otherwise the stored value.
    function automatic logic [DATA_W-1:0] bypass_read(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              we,
        input logic [ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0] wdata
    );
        logic [DATA_W-1:0] result;
        if (addr == '0)
            result = '0;
        else if (we && (waddr == addr))
            result = wdata;
        else
            result = stored;
        return result;
    endfunction

    // Register array update; writes to r0 are dropped so it stays zero.
    // NOTE: the array must be cleared by reset, so it is built from flops
    // with an async clear rather than mapped onto a RAM macro.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (bus.we && (bus.waddr != '0)) begin
            // NOTE: sequential state always uses non-blocking assignment.
            regs[bus.waddr] <= bus.wdata;
        end
    end

    // Combinational read ports and the sequencer's internal read tap.
    always_comb begin
        bus.rdata1 = bypass_read(bus.raddr1, regs[bus.raddr1], bus.we, bus.waddr, bus.wdata);
        bus.rdata2 = bypass_read(bus.raddr2, regs[bus.raddr2], bus.we, bus.waddr, bus.wdata);
        idx_rdata  = bypass_read(idx, regs[idx], bus.we, bus.waddr, bus.wdata);
    end

    // Debug readback sequencer: LOAD captures one word, SEND holds it until
    // accepted, DONE pulses once after the last register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            idx     <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.dump_start) begin
                        idx    <= '0;
                        busy_q <= 1'b1;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    // The captured word is a snapshot; later writes to
                    // regs[idx] do not disturb it.
                    data_q  <= idx_rdata;
                    addr_q  <= idx;
                    valid_q <= 1'b1;
                    state   <= SEND;
                end
                SEND: begin
                    if (valid_q && bus.dump_ready) begin
                        valid_q <= 1'b0;
                        if (idx == ADDR_W'(NREGS - 1)) begin
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            idx   <= idx + ADDR_W'(1);
                            state <= LOAD;
                        end
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    idx    <= '0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sequencer outputs come straight from registers.
    always_comb begin
        bus.dump_busy  = busy_q;
        bus.dump_valid = valid_q;
        bus.dump_done  = done_q;
        bus.dump_addr  = addr_q;
        bus.dump_data  = data_q;
    end

endmodule

// File: tb/tb_regfile_reader.sv
// Bench for regfile_reader: directed read/write/bypass checks plus a
// scoreboard of expected dump words, popped as the DUT hands them over.
module tb_regfile_reader;
    localparam int DATA_W = 32;
    localparam int NREGS  = 32;
    localparam int ADDR_W = 5;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } word_t;

    logic CLK = 1'b0;
    logic RST_N;

    always #5 CLK = ~CLK;

    regfile_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_reader #(.DATA_W(DATA_W), .NREGS(NREGS), .ADDR_W(ADDR_W)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    word_t             sb [$];
    logic [DATA_W-1:0] model [NREGS];
    int                n_vec = 0;
    int                n_miss = 0;
    int                beats = 0;
    bit                done_seen = 1'b0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_word(input int a, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (bus.dump_valid && (bus.dump_addr == ADDR_W'(a))) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic push_dump();
        for (int i = 0; i < NREGS; i++)
            sb.push_back('{addr: ADDR_W'(i), data: model[i]});
    endtask

    // Scoreboard side: every accepted beat must match the next expected word.
    always @(negedge CLK) begin
        word_t w;
        if (RST_N && bus.dump_valid && bus.dump_ready) begin
            check("beat_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                w = sb.pop_front();
                check("dump_addr", 64'(bus.dump_addr), 64'(w.addr));
                check("dump_data", 64'(bus.dump_data), 64'(w.data));
            end
            beats++;
        end
        if (bus.dump_done)
            done_seen = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          done_edge;
        bit          ok;
        logic [DATA_W-1:0] old3;

        RST_N          = 1'b0;
        bus.we         = 1'b0;
        bus.waddr      = '0;
        bus.wdata      = '0;
        bus.raddr1     = '0;
        bus.raddr2     = '0;
        bus.dump_start = 1'b0;
        bus.dump_ready = 1'b0;
        for (int i = 0; i < NREGS; i++) model[i] = '0;

        // Reset then read.
        repeat (3) tick();
        RST_N      = 1'b1;
        bus.raddr1 = 5'd7;
        bus.raddr2 = 5'd31;
        tick();
        check("rst_rdata1", 64'(bus.rdata1), 64'd0);
        check("rst_rdata2", 64'(bus.rdata2), 64'd0);
        check("rst_busy",   64'(bus.dump_busy), 64'd0);
        check("rst_valid",  64'(bus.dump_valid), 64'd0);
        check("rst_done",   64'(bus.dump_done), 64'd0);

        // Write with same-cycle bypass, then registered readback.
        bus.we     = 1'b1;
        bus.waddr  = 5'd5;
        bus.wdata  = 32'hDEADBEEF;
        bus.raddr1 = 5'd5;
        #1 check("bypass_rdata1", 64'(bus.rdata1), 64'hDEADBEEF);
        model[5] = 32'hDEADBEEF;
        tick();
        bus.we = 1'b0;
        #1 check("stored_rdata1", 64'(bus.rdata1), 64'hDEADBEEF);

        // r0 stays zero even under a write.
        bus.we     = 1'b1;
        bus.waddr  = 5'd0;
        bus.wdata  = 32'h12345678;
        bus.raddr1 = 5'd0;
        #1 check("r0_same_cycle", 64'(bus.rdata1), 64'd0);
        tick();
        bus.we = 1'b0;
        #1 check("r0_next_cycle", 64'(bus.rdata1), 64'd0);

        // Preload pattern.
        for (int i = 1; i < NREGS; i++) begin
            bus.we    = 1'b1;
            bus.waddr = ADDR_W'(i);
            bus.wdata = (i < 16) ? DATA_W'(i) * 32'h11111111 : 32'hA5A50000 + DATA_W'(i);
            model[i]  = bus.wdata;
            tick();
        end
        bus.we     = 1'b0;
        bus.raddr1 = 5'd15;
        bus.raddr2 = 5'd16;
        #1;
        check("preload_r15", 64'(bus.rdata1), 64'hFFFFFFFF);
        check("preload_r16", 64'(bus.rdata2), 64'hA5A50010);

        // Full dump with READY held high.
        push_dump();
        beats          = 0;
        bus.dump_ready = 1'b1;
        bus.dump_start = 1'b1;
        tick();
        bus.dump_start = 1'b0;
        done_edge = -1;
        for (int n = 1; n <= 100 && done_edge < 0; n++) begin
            tick();
            if (n == 1)
                check("busy_after_start", 64'(bus.dump_busy), 64'd1);
            if (bus.dump_done)
                done_edge = n;
        end
        check("done_edge", 64'(done_edge), 64'(2 * NREGS));
        check("busy_in_done", 64'(bus.dump_busy), 64'd1);
        tick();
        check("busy_after_done", 64'(bus.dump_busy), 64'd0);
        check("done_single", 64'(bus.dump_done), 64'd0);
        check("beats_full", 64'(beats), 64'(NREGS));
        check("sb_drained", 64'(sb.size()), 64'd0);

        // Second dump: backpressure on word 3, ignored start, abort at word 20.
        push_dump();
        old3      = model[3];
        done_seen = 1'b0;
        bus.dump_start = 1'b1;
        tick();
        bus.dump_start = 1'b0;
        wait_word(3, ok);
        check("reach_word3", 64'(ok), 64'd1);
        bus.dump_ready = 1'b0;
        bus.we         = 1'b1;
        bus.waddr      = 5'd3;
        bus.wdata      = 32'hFFFFFFFF;
        model[3]       = 32'hFFFFFFFF;
        for (int k = 0; k < 5; k++) begin
            tick();
            bus.we = 1'b0;
            check("hold_valid", 64'(bus.dump_valid), 64'd1);
            check("hold_addr",  64'(bus.dump_addr), 64'd3);
            check("hold_data",  64'(bus.dump_data), 64'(old3));
        end
        bus.raddr1 = 5'd3;
        #1 check("r3_updated", 64'(bus.rdata1), 64'hFFFFFFFF);
        bus.dump_ready = 1'b1;
        tick();
        check("load_gap_valid", 64'(bus.dump_valid), 64'd0);
        tick();
        check("word4_valid", 64'(bus.dump_valid), 64'd1);
        check("word4_addr",  64'(bus.dump_addr), 64'd4);

        wait_word(10, ok);
        check("reach_word10", 64'(ok), 64'd1);
        bus.dump_start = 1'b1;
        tick();
        bus.dump_start = 1'b0;

        wait_word(20, ok);
        check("reach_word20", 64'(ok), 64'd1);
        RST_N = 1'b0;
        #1;
        check("abort_valid", 64'(bus.dump_valid), 64'd0);
        check("abort_busy",  64'(bus.dump_busy), 64'd0);
        check("abort_addr",  64'(bus.dump_addr), 64'd0);
        check("abort_data",  64'(bus.dump_data), 64'd0);
        check("abort_pending", 64'(sb.size()), 64'(NREGS - 20));
        sb.delete();
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        repeat (3) tick();
        RST_N = 1'b1;
        repeat (2) tick();
        check("abort_no_done", 64'(done_seen), 64'd0);
        check("abort_busy_idle", 64'(bus.dump_busy), 64'd0);
        for (int a = 0; a < NREGS; a++) begin
            bus.raddr1 = ADDR_W'(a);
            bus.raddr2 = ADDR_W'(NREGS - 1 - a);
            #1;
            check("post_rst_rd1", 64'(bus.rdata1), 64'(model[a]));
            check("post_rst_rd2", 64'(bus.rdata2), 64'(model[NREGS - 1 - a]));
        end
        bus.dump_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
